// File: rtl/picomips_sequencer_pkg.sv
// Shared picoMIPS definitions: opcode constants, sequencer state encoding
// and the ALU-class decode used by both the decoder and the sequencer.
package picomips_sequencer_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd1;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd2;
    localparam logic [OP_W-1:0] OP_MUL   = 6'd3;
    localparam logic [OP_W-1:0] OP_MULI  = 6'd4;
    localparam logic [OP_W-1:0] OP_LDSW  = 6'd5;
    localparam logic [OP_W-1:0] OP_WAITH = 6'd6;
    localparam logic [OP_W-1:0] OP_WAITL = 6'd7;
    localparam logic [OP_W-1:0] OP_JMP   = 6'd8;
    localparam logic [OP_W-1:0] OP_HALT  = 6'd9;

    typedef enum logic [2:0] {
        S_START   = 3'd0,
        S_RUN     = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_HALT    = 3'd4
    } picomips_state_t;

    // Instructions that write the register file.
    function automatic logic is_alu(input logic [OP_W-1:0] op);
        logic r;
        case (op)
            OP_ADD, OP_ADDI, OP_MUL, OP_MULI, OP_LDSW: r = 1'b1;
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/picomips_sequencer_debouncer.sv
// Two-flop synchroniser plus stability counter for the asynchronous board
// switch; sw_db only follows after DB_CYCLES consecutive differing cycles.
module switch_debouncer
    import picomips_sequencer_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic SW8,
    output logic sw_db
);

    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_r;
    logic          sw_sync_r;
    logic          sw_db_r;
    logic [CW-1:0] cnt_r;

    // Synchroniser chain for the raw switch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r   <= 1'b0;
            sw_sync_r <= 1'b0;
        end else begin
            sync1_r   <= SW8;
            sw_sync_r <= sync1_r;
        end
    end

    // Stability counter; any return to agreement restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_db_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (sw_sync_r == sw_db_r) begin
            cnt_r   <= {CW{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
            sw_db_r <= sw_sync_r;
            cnt_r   <= {CW{1'b0}};
        end else begin
            cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign sw_db = sw_db_r;

endmodule

// File: rtl/picomips_sequencer.sv
// picoMIPS instruction sequencer: owns the PC, steps one instruction per
// cycle, stalls on switch handshakes, and supports JMP and a terminal HALT.
module picomips_sequencer
    import picomips_sequencer_pkg::*;
#(
    parameter int P_SIZE    = 4,
    parameter int O_SIZE    = 6,
    parameter int DB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [O_SIZE-1:0] opcode,
    input  logic [P_SIZE-1:0] target,
    input  logic              SW8,
    output logic [P_SIZE-1:0] PCout,
    output logic              regWrite,
    output logic              waiting,
    output logic              halted
);

    localparam int OW = (O_SIZE > OP_W) ? O_SIZE : OP_W;
    localparam logic [P_SIZE-1:0] PC_ONE = {{(P_SIZE-1){1'b0}}, 1'b1};

    picomips_state_t   state_r;
    picomips_state_t   state_next_s;
    logic [P_SIZE-1:0] pc_r;
    logic [P_SIZE-1:0] pc_next_s;
    logic [P_SIZE-1:0] pc_inc_s;
    logic              reg_write_s;
    logic              sw_db_s;
    logic [OW-1:0]     op_ext_s;
    logic [OP_W-1:0]   op_s;

    switch_debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debouncer (
        .clk   (clk),
        .reset (reset),
        .SW8   (SW8),
        .sw_db (sw_db_s)
    );

    // Unrecognised opcodes, including wide ones beyond the table, fold to NOP.
    always_comb begin
        op_ext_s = OW'(opcode);
        if (op_ext_s > OW'(OP_HALT)) begin
            op_s = OP_NOP;
        end else begin
            op_s = op_ext_s[OP_W-1:0];
        end
    end

    assign pc_inc_s = pc_r + PC_ONE;

    // Next-state, next-PC and register write enable.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        reg_write_s  = 1'b0;
        case (state_r)
            S_START: begin
                state_next_s = S_RUN;
                pc_next_s    = {P_SIZE{1'b0}};
            end
            S_RUN: begin
                case (op_s)
                    OP_WAITH: begin
                        if (sw_db_s) begin
                            pc_next_s = pc_inc_s;
                        end else begin
                            state_next_s = S_WAIT_HI;
                        end
                    end
                    OP_WAITL: begin
                        if (!sw_db_s) begin
                            pc_next_s = pc_inc_s;
                        end else begin
                            state_next_s = S_WAIT_LO;
                        end
                    end
                    OP_JMP: begin
                        pc_next_s = target;
                    end
                    OP_HALT: begin
                        state_next_s = S_HALT;
                    end
                    default: begin
                        pc_next_s   = pc_inc_s;
                        reg_write_s = is_alu(op_s);
                    end
                endcase
            end
            S_WAIT_HI: begin
                if (sw_db_s) begin
                    pc_next_s    = pc_inc_s;
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_WAIT_HI;
                end
            end
            S_WAIT_LO: begin
                if (!sw_db_s) begin
                    pc_next_s    = pc_inc_s;
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_WAIT_LO;
                end
            end
            S_HALT: begin
                state_next_s = S_HALT;
            end
            default: begin
                state_next_s = S_START;
                pc_next_s    = {P_SIZE{1'b0}};
            end
        endcase
    end

    // State and program counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_START;
            pc_r    <= {P_SIZE{1'b0}};
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
        end
    end

    assign PCout    = pc_r;
    assign regWrite = reg_write_s;
    assign waiting  = (state_r == S_WAIT_HI) || (state_r == S_WAIT_LO);
    assign halted   = (state_r == S_HALT);

endmodule

// File: tb/tb_picomips_sequencer.sv
// Directed bench for picomips_sequencer: program sequencing, PC wrap,
// switch handshakes with debounce, HALT and asynchronous reset.
module tb_picomips_sequencer;

    localparam int P_SIZE    = 4;
    localparam int O_SIZE    = 6;
    localparam int DB_CYCLES = 4;

    localparam logic [5:0] NOP   = 6'd0;
    localparam logic [5:0] ADD   = 6'd1;
    localparam logic [5:0] ADDI  = 6'd2;
    localparam logic [5:0] WAITH = 6'd6;
    localparam logic [5:0] WAITL = 6'd7;
    localparam logic [5:0] JMP   = 6'd8;
    localparam logic [5:0] HALT  = 6'd9;

    logic              clk;
    logic              reset;
    logic [O_SIZE-1:0] opcode;
    logic [P_SIZE-1:0] target;
    logic              SW8;
    logic [P_SIZE-1:0] PCout;
    logic              regWrite;
    logic              waiting;
    logic              halted;

    logic [O_SIZE-1:0] prog_op  [16];
    logic [P_SIZE-1:0] prog_tgt [16];

    int checks;
    int failures;

    picomips_sequencer #(
        .P_SIZE    (P_SIZE),
        .O_SIZE    (O_SIZE),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .target   (target),
        .SW8      (SW8),
        .PCout    (PCout),
        .regWrite (regWrite),
        .waiting  (waiting),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign opcode = prog_op[PCout];
    assign target = prog_tgt[PCout];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) begin
            prog_op[i]  = NOP;
            prog_tgt[i] = 4'd0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pc"},  32'(PCout),    32'd0);
        check_eq({tag, "_rw"},  32'(regWrite), 32'd0);
        check_eq({tag, "_wt"},  32'(waiting),  32'd0);
        check_eq({tag, "_hlt"}, 32'(halted),   32'd0);
    endtask

    // Assert reset mid-cycle, observe it acting before any edge, release at negedge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        SW8      = 1'b0;
        fill_nop();

        // Sequencing with JMP back to 0.
        prog_op[0] = ADD;
        prog_op[1] = ADDI;
        prog_op[2] = NOP;
        prog_op[3] = JMP;
        prog_tgt[3] = 4'd0;
        #1;
        check_reset_outputs("por");
        do_reset("rst1");
        check_eq("start_pc", 32'(PCout), 32'd0);
        check_eq("start_rw", 32'(regWrite), 32'd0);
        begin
            logic [3:0] exp_pc [6];
            logic       exp_rw [6];
            exp_pc = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
            exp_rw = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            for (int i = 0; i < 6; i++) begin
                step(1);
                check_eq($sformatf("seq_pc%0d", i), 32'(PCout), 32'(exp_pc[i]));
                check_eq($sformatf("seq_rw%0d", i), 32'(regWrite), 32'(exp_rw[i]));
            end
        end

        // All NOP: PC walks to 15 and wraps to 0.
        fill_nop();
        do_reset("rst2");
        step(16);
        check_eq("wrap_pc15", 32'(PCout), 32'd15);
        check_eq("wrap_rw", 32'(regWrite), 32'd0);
        step(1);
        check_eq("wrap_pc0", 32'(PCout), 32'd0);
        check_eq("wrap_wt", 32'(waiting), 32'd0);

        // WAITH at 2, WAITL at 3.
        fill_nop();
        prog_op[0] = ADD;
        prog_op[2] = WAITH;
        prog_op[3] = WAITL;
        do_reset("rst3");
        step(4);
        check_eq("waith_pc", 32'(PCout), 32'd2);
        check_eq("waith_wt", 32'(waiting), 32'd1);
        step(3);
        check_eq("waith_hold", 32'(PCout), 32'd2);

        // Three-cycle glitch is filtered.
        SW8 = 1'b1;
        step(3);
        SW8 = 1'b0;
        step(10);
        check_eq("glitch_pc", 32'(PCout), 32'd2);
        check_eq("glitch_wt", 32'(waiting), 32'd1);

        // Stable rise releases exactly 2+DB_CYCLES+1 edges later.
        SW8 = 1'b1;
        step(6);
        check_eq("rise_pc_e6", 32'(PCout), 32'd2);
        check_eq("rise_wt_e6", 32'(waiting), 32'd1);
        step(1);
        check_eq("rise_pc_e7", 32'(PCout), 32'd3);
        check_eq("rise_wt_e7", 32'(waiting), 32'd0);
        step(1);
        check_eq("waitl_pc", 32'(PCout), 32'd3);
        check_eq("waitl_wt", 32'(waiting), 32'd1);
        step(2);
        check_eq("waitl_hold", 32'(PCout), 32'd3);

        // Reset while in WAIT_LO, then restart from address 0.
        SW8 = 1'b0;
        do_reset("rst_wlo");
        check_eq("rs_start_pc", 32'(PCout), 32'd0);
        check_eq("rs_start_rw", 32'(regWrite), 32'd0);
        step(1);
        check_eq("rs_run_pc", 32'(PCout), 32'd0);
        check_eq("rs_run_rw", 32'(regWrite), 32'd1);
        step(1);
        check_eq("rs_run_pc1", 32'(PCout), 32'd1);

        // HALT at 5 is absorbing until reset.
        fill_nop();
        prog_op[4] = ADD;
        prog_op[5] = HALT;
        do_reset("rst4");
        step(6);
        check_eq("halt_pc_exec", 32'(PCout), 32'd5);
        check_eq("halt_h_exec", 32'(halted), 32'd0);
        step(1);
        check_eq("halt_pc", 32'(PCout), 32'd5);
        check_eq("halt_h", 32'(halted), 32'd1);
        step(8);
        check_eq("halt_pc_late", 32'(PCout), 32'd5);
        check_eq("halt_h_late", 32'(halted), 32'd1);
        check_eq("halt_rw", 32'(regWrite), 32'd0);
        do_reset("rst_halt");
        step(1);
        check_eq("post_halt_pc", 32'(PCout), 32'd0);
        check_eq("post_halt_h", 32'(halted), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/picomips_sequencer.md
# picomips_sequencer

Multi-cycle instruction sequencer for the picoMIPS control path. It owns the program counter and steps through program memory, one instruction per cycle, and asserts the register-file write enable for ALU instructions. It stalls on switch-handshake instructions (WAITH/WAITL) against a synchronised, debounced SW[8]. It supports absolute jumps and a terminal HALT, replacing the bare PC-increment path between the decoder and the `pc` block.

## Interface
- P_SIZE, 4: program-counter width; program memory depth is 2^P_SIZE.
- O_SIZE, 6: opcode width.
- DB_CYCLES, 16: consecutive stable cycles required before the debounced switch changes; must be ≥1.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  O_SIZE  opcode of the instruction at PCout, from program memory (combinational).
- target  input  P_SIZE  low P_SIZE bits of the instruction, used as the JMP destination.
- SW8  input  1  raw board switch, asynchronous to clk.
- PCout  output  P_SIZE  current program counter, which addresses program memory.
- regWrite  output  1  register-file write enable for the instruction at PCout.
- waiting  output  1  high while stalled in WAIT_HI or WAIT_LO.
- halted  output  1  high in HALT.

## Operation
- Opcodes, from opcodes.sv:
  - NOP=0, ADD=1, ADDI=2, MUL=3, MULI=4, LDSW=5, WAITH=6, WAITL=7, JMP=8, HALT=9.
  - Any other value executes as NOP.
- ALU class is {ADD, ADDI, MUL, MULI, LDSW}.
- States: START, RUN, WAIT_HI, WAIT_LO, HALT.
- START: no instruction executes; PC holds at 0. The next state is always RUN.
- RUN executes the instruction at PCout this cycle:
  - ALU class or NOP: PC ← PC+1.
  - WAITH: if sw_db=1, PC ← PC+1 and stay in RUN; else hold PC and go to WAIT_HI.
  - WAITL: same as WAITH with sw_db=0 as the release condition; otherwise go to WAIT_LO.
  - JMP: PC ← target.
  - HALT: hold PC and go to HALT.
- WAIT_HI: hold PC until sw_db=1, then PC ← PC+1 and return to RUN in the same edge.
- WAIT_LO: same as WAIT_HI, releasing on sw_db=0.
- HALT: absorbing; only reset leaves it. PC is frozen.
- regWrite is combinational: 1 iff state=RUN and opcode is in the ALU class. It is 0 in every other state.
- waiting = (state ∈ {WAIT_HI, WAIT_LO}); halted = (state=HALT). Both are decoded from the state register.
- PC arithmetic is unsigned modulo 2^P_SIZE: PC+1 wraps 2^P_SIZE−1 → 0 with no flag. JMP to the current PC is a legal spin loop.
- Switch conditioning:
  - A two-flop synchroniser feeds sw_sync.
  - Counter cnt is cleared whenever sw_sync = sw_db.
  - While they differ, cnt increments each cycle. On the cycle that cnt = DB_CYCLES−1 with them still differing, sw_db ← sw_sync and cnt ← 0.
  - A glitch shorter than DB_CYCLES synchronised cycles never reaches sw_db.
  - cnt width is $clog2(DB_CYCLES)+1.

## Timing
- Reset (asynchronous, immediate):
  - state=START, PC=0, sync flops=0, sw_db=0, cnt=0.
  - Outputs: PCout=0, regWrite=0, waiting=0, halted=0.
- First instruction (address 0) executes in the second cycle after reset deassertion: one START cycle, then RUN.
- Throughput is one instruction per cycle in RUN. A WAIT whose condition already holds costs one cycle.
- SW8 to sw_db latency is 2 + DB_CYCLES rising edges after a stable change.
- A WAIT stall releases on the first edge at which sw_db satisfies its condition. The next instruction executes in the following cycle.
- Reset asserted mid-wait or in HALT returns to START with PC=0; the debouncer is cleared.
- Simultaneous edge when sw_db flips on the same edge the sequencer samples it: the sequencer uses the pre-edge sw_db value.

## Structure
- Opcode constants and the state enum (picomips_state_t) belong in the shared opcodes.sv package, shared with the decoder.
- One sub-module: switch_debouncer (synchroniser + counter; params DB_CYCLES; ports clk, reset, SW8, sw_db).
- The sequencer FSM and PC register live in picomips_sequencer.

## Test plan
- Reset then program {0:ADD, 1:ADDI, 2:NOP, 3:JMP→0} → PCout 0,0,1,2,3,0,1…; regWrite=1 only when PCout∈{0,1} and state=RUN.
- P_SIZE=4, program all NOP → PCout 15 followed by 0 (wrap), with no stall.
- DB_CYCLES=4, WAITH at address 2, SW8 low → PCout holds 2 and waiting=1. Raise SW8 → PCout becomes 3 exactly 2+4+1 edges later, and waiting drops the same edge.
- SW8 pulse of 3 cycles with DB_CYCLES=4 during WAITH → sw_db stays 0 and PCout stays 2.
- HALT at address 5 → PCout=5 and halted=1 indefinitely, regWrite=0. Assert reset → PCout=0 and halted=0 immediately, asynchronously.
- Reset asserted while in WAIT_LO → outputs return to reset values, and execution restarts from address 0 after one START cycle.
